// File: rtl/ulpi_pkg.sv
// Shared types and constants for the ULPI PHY-side responder: FSM states,
// RX CMD event codes, the TX CMD type code and the RX CMD byte builder.
package ulpi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_DATA,
    RX_TURN,
    RX_CMD,
    RX_DATA,
    RX_END,
    RX_BACK
  } ulpi_state_t;

  localparam logic [1:0] RX_EVENT_ACTIVE = 2'b01;
  localparam logic [1:0] RX_EVENT_NONE   = 2'b00;
  localparam logic [1:0] TXCMD_TRANSMIT  = 2'b01;

  // RX CMD layout: [7:6] reserved, [5:4] RxEvent, [3:2] VbusState, [1:0] LineState
  function automatic logic [7:0] rx_cmd_byte(input logic [1:0] evt,
                                             input logic [1:0] vbus,
                                             input logic [1:0] ls);
    return {2'b00, evt, vbus, ls};
  endfunction

endpackage

// File: rtl/ulpi_tx_capture.sv
// Link transmit payload capture: one-byte hold register so the byte preceding
// stp can be flagged as last; outputs are a registered one-cycle strobe.
module ulpi_tx_capture (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       active,
  input  logic       stp,
  input  logic [7:0] link_data,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic       tx_last
);

  logic [7:0] hold_q;
  logic       hold_valid_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_q       <= 8'h00;
      hold_valid_q <= 1'b0;
      tx_byte      <= 8'h00;
      tx_valid     <= 1'b0;
      tx_last      <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      tx_last  <= 1'b0;
      if (active) begin
        // The bus byte in the stp cycle is not payload; only the held byte is flushed.
        if (hold_valid_q) begin
          tx_valid <= 1'b1;
          tx_byte  <= hold_q;
          tx_last  <= stp;
        end
        if (stp) begin
          hold_valid_q <= 1'b0;
        end else begin
          hold_q       <= link_data;
          hold_valid_q <= 1'b1;
        end
      end else begin
        hold_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ulpi_phy_model.sv
// ULPI PHY-side responder: owns dir/nxt, captures link TX packets, sends RX packets.
// Build option ULPI_LINESTATE_RXCMD_EN adds unsolicited linestate RX CMDs from IDLE.
module ulpi_phy_model
  import ulpi_pkg::*;
#(
  parameter logic [1:0] RX_VBUS = 2'b00
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  link_data,
  input  logic        stp,
  output logic [7:0]  phy_data,
  output logic        dir,
  output logic        nxt,
  input  logic [1:0]  linestate,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_last,
  output logic        rx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  output logic        tx_last,
  output logic [3:0]  tx_pid,
  output ulpi_state_t state_dbg
);

  ulpi_state_t state_q, state_d;
  logic        dir_d, nxt_d, pid_load;
  logic [7:0]  phy_d;
  logic        rx_done_q, rx_done_d;
  logic        tx_cmd_seen;
  logic [7:0]  cmd_start, cmd_end;
  logic        ls_change, ls_only_q;

  assign tx_cmd_seen = (link_data[7:6] == TXCMD_TRANSMIT);
  assign cmd_start   = rx_cmd_byte(RX_EVENT_ACTIVE, RX_VBUS, linestate);
  assign cmd_end     = rx_cmd_byte(RX_EVENT_NONE, RX_VBUS, linestate);
  assign state_dbg   = state_q;

`ifdef ULPI_LINESTATE_RXCMD_EN
  logic [1:0] ls_q;
  logic       ls_start;

  assign ls_change = (linestate != ls_q);
  // Only an IDLE->RX_TURN move without rx_valid is a linestate report.
  assign ls_start  = (state_q == IDLE) && (state_d == RX_TURN) && !rx_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ls_q      <= 2'b00;
      ls_only_q <= 1'b0;
    end else begin
      ls_only_q <= ls_start;
      if (ls_start) ls_q <= linestate;
    end
  end
`else
  assign ls_change = 1'b0;
  assign ls_only_q = 1'b0;
`endif

  // RX source handshake: a byte moves when rx_valid && rx_ready in the same cycle;
  // rx_valid must hold its byte until then. The byte is on phy_data the next cycle.
  // Bus outputs are registered, so each branch computes the values for next cycle.
  always_comb begin
    state_d   = state_q;
    dir_d     = 1'b0;
    nxt_d     = 1'b0;
    phy_d     = 8'h00;
    rx_ready  = 1'b0;
    rx_done_d = rx_done_q;
    pid_load  = 1'b0;
    case (state_q)
      IDLE: begin
        rx_done_d = 1'b0;
        if (tx_cmd_seen) begin
          state_d = TX_CMD;
          nxt_d   = 1'b1;
        end else if (rx_valid || ls_change) begin
          state_d = RX_TURN;
          dir_d   = 1'b1;
        end
      end
      TX_CMD: begin
        pid_load = 1'b1;
        if (stp) begin
          state_d = IDLE;
        end else begin
          state_d = TX_DATA;
          nxt_d   = 1'b1;
        end
      end
      TX_DATA: begin
        if (stp) state_d = IDLE;
        else     nxt_d   = 1'b1;
      end
      RX_TURN: begin
        dir_d = 1'b1;
        if (ls_only_q) begin
          state_d = RX_END;
          phy_d   = cmd_end;
        end else begin
          state_d = RX_CMD;
          phy_d   = cmd_start;
        end
      end
      RX_CMD, RX_DATA: begin
        dir_d = 1'b1;
        if (rx_done_q) begin
          state_d = RX_END;
          phy_d   = cmd_end;
        end else begin
          state_d = RX_DATA;
          if (rx_valid) begin
            rx_ready  = 1'b1;
            nxt_d     = 1'b1;
            phy_d     = rx_byte;
            rx_done_d = rx_last;
          end else begin
            phy_d = cmd_start;
          end
        end
      end
      RX_END: begin
        state_d = RX_BACK;
        dir_d   = 1'b1;
      end
      RX_BACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      dir       <= 1'b0;
      nxt       <= 1'b0;
      phy_data  <= 8'h00;
      tx_pid    <= 4'h0;
      rx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir       <= dir_d;
      nxt       <= nxt_d;
      phy_data  <= phy_d;
      rx_done_q <= rx_done_d;
      if (pid_load) tx_pid <= link_data[3:0];
    end
  end

  ulpi_tx_capture u_tx_capture (
    .clk       (clk),
    .n_rst     (n_rst),
    .active    (state_q == TX_DATA),
    .stp       (stp),
    .link_data (link_data),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last)
  );

endmodule

// File: tb/tb_ulpi_phy_model.sv
// Bench for ulpi_phy_model: TX capture and RX bus sequences checked through
// expected-value queues filled by the driver tasks.
module tb_ulpi_phy_model;
  import ulpi_pkg::*;

  logic        clk;
  logic        n_rst;
  logic [7:0]  link_data;
  logic        stp;
  logic [7:0]  phy_data;
  logic        dir;
  logic        nxt;
  logic [1:0]  linestate;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_last;
  logic [3:0]  tx_pid;
  ulpi_state_t state_dbg;

  ulpi_phy_model dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .link_data (link_data),
    .stp       (stp),
    .phy_data  (phy_data),
    .dir       (dir),
    .nxt       (nxt),
    .linestate (linestate),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_last   (rx_last),
    .rx_ready  (rx_ready),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_pid    (tx_pid),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int dir_cycles = 0;

  logic [8:0] tx_exp_q[$];   // {last, byte}
  logic [8:0] bus_exp_q[$];  // {nxt, phy_data} for every dir=1 cycle
  logic [8:0] tx_exp, bus_exp;
  logic [7:0] tx_pkt [8];
  logic [7:0] rx_pkt [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_cmd(input logic active, input logic [1:0] ls);
    return {2'b00, 1'b0, active, 2'b00, ls};
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (n_rst) begin
      if (dir) dir_cycles++;
      if (tx_valid) begin
        if (tx_exp_q.size() == 0) begin
          check("tx_extra", 32'(tx_exp_q.size()), 32'd1);
        end else begin
          tx_exp = tx_exp_q.pop_front();
          check("tx_out", 32'({tx_last, tx_byte}), 32'(tx_exp));
        end
      end
      if (dir) begin
        if (bus_exp_q.size() == 0) begin
          check("bus_extra", 32'(bus_exp_q.size()), 32'd1);
        end else begin
          bus_exp = bus_exp_q.pop_front();
          check("bus_out", 32'({nxt, phy_data}), 32'(bus_exp));
        end
      end
    end
  end

  // driver tasks
  task automatic check_reset_vals(input string tag);
    check({tag, "_dir"},      32'(dir), 32'd0);
    check({tag, "_nxt"},      32'(nxt), 32'd0);
    check({tag, "_phy"},      32'(phy_data), 32'd0);
    check({tag, "_txv"},      32'(tx_valid), 32'd0);
    check({tag, "_txl"},      32'(tx_last), 32'd0);
    check({tag, "_txb"},      32'(tx_byte), 32'd0);
    check({tag, "_pid"},      32'(tx_pid), 32'd0);
    check({tag, "_rdy"},      32'(rx_ready), 32'd0);
    check({tag, "_state"},    32'(state_dbg), 32'(IDLE));
  endtask

  // Called at posedge+1 of the cycle in which the TX CMD is to appear.
  task automatic send_tx(input logic [3:0] pid, input int n);
    logic last;
    link_data = {4'b0100, pid};
    @(negedge clk); check("tx_nxt_idle", 32'(nxt), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("tx_nxt_cmd", 32'(nxt), 32'd1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      last = (i == n - 1);
      link_data = tx_pkt[i];
      tx_exp_q.push_back({last, tx_pkt[i]});
      @(negedge clk); check("tx_nxt_data", 32'(nxt), 32'd1);
    end
    @(posedge clk); #1;
    link_data = 8'h00;
    stp = 1'b1;
    @(negedge clk); check("tx_nxt_stp", 32'(nxt), 32'd1);
    @(posedge clk); #1;
    stp = 1'b0;
    @(negedge clk);
    check("tx_nxt_end", 32'(nxt), 32'd0);
    check("tx_pid", 32'(tx_pid), 32'(pid));
  endtask

  task automatic rx_expect(input int n, input logic [1:0] ls, input int gap_idx, input int gap_len);
    dir_cycles = 0;
    bus_exp_q.push_back({1'b0, 8'h00});
    bus_exp_q.push_back({1'b0, exp_cmd(1'b1, ls)});
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx && i > 0)
        for (int g = 0; g < gap_len; g++) bus_exp_q.push_back({1'b0, exp_cmd(1'b1, ls)});
      bus_exp_q.push_back({1'b1, rx_pkt[i]});
    end
    bus_exp_q.push_back({1'b0, exp_cmd(1'b0, ls)});
    bus_exp_q.push_back({1'b0, 8'h00});
  endtask

  task automatic rx_feed(input int n, input int gap_idx, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_idx && i > 0) begin
        rx_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      rx_valid = 1'b1;
      rx_byte  = rx_pkt[i];
      rx_last  = (i == n - 1);
      @(negedge clk);
      for (int t = 0; t < 40 && !rx_ready; t++) @(negedge clk);
      check("rx_ready", 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic finish_pkt(input int exp_dir);
    for (int t = 0; t < 40 && dir; t++) @(negedge clk);
    check("dir_low", 32'(dir), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("tx_q_drained", 32'(tx_exp_q.size()), 32'd0);
    check("bus_q_drained", 32'(bus_exp_q.size()), 32'd0);
    check("dir_cycles", 32'(dir_cycles), 32'(exp_dir));
    tx_exp_q.delete();
    bus_exp_q.delete();
  endtask

  task automatic set_ls(input logic [1:0] ls);
    int exp_dir;
    @(posedge clk); #1;
    dir_cycles = 0;
`ifdef ULPI_LINESTATE_RXCMD_EN
    bus_exp_q.push_back({1'b0, 8'h00});
    bus_exp_q.push_back({1'b0, 6'b000000, ls});
    bus_exp_q.push_back({1'b0, 8'h00});
    exp_dir = 3;
`else
    exp_dir = 0;
`endif
    linestate = ls;
    repeat (2) @(negedge clk);
    finish_pkt(exp_dir);
  endtask

  // stimulus
  initial begin
    int n, gi, gl;
    logic [3:0] pid;
    n_rst = 1'b0;
    link_data = 8'h00;
    stp = 1'b0;
    linestate = 2'b00;
    rx_byte = 8'h00;
    rx_valid = 1'b0;
    rx_last = 1'b0;
    #3;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst_rel_state", 32'(state_dbg), 32'(IDLE));
    check("rst_rel_dir", 32'(dir), 32'd0);

    // TX CMD 0x41, AA BB CC
    tx_pkt[0] = 8'hAA; tx_pkt[1] = 8'hBB; tx_pkt[2] = 8'hCC;
    @(posedge clk); #1;
    dir_cycles = 0;
    send_tx(4'h1, 3);
    finish_pkt(0);

    // random TX packets
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 6);
      pid = 4'($urandom_range(0, 15));
      for (int i = 0; i < n; i++) tx_pkt[i] = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      dir_cycles = 0;
      send_tx(pid, n);
      finish_pkt(0);
    end

    // RX AA 55 with linestate 01
    set_ls(2'b01);
    rx_pkt[0] = 8'hAA; rx_pkt[1] = 8'h55;
    @(posedge clk); #1;
    rx_expect(2, 2'b01, 9, 0);
    rx_feed(2, 9, 0);
    finish_pkt(6);
    set_ls(2'b00);

    // underrun: rx_valid low for 2 cycles before byte 2
    rx_pkt[0] = 8'h01; rx_pkt[1] = 8'h82; rx_pkt[2] = 8'h43; rx_pkt[3] = 8'hC4;
    @(posedge clk); #1;
    rx_expect(4, 2'b00, 2, 2);
    rx_feed(4, 2, 2);
    finish_pkt(10);

    // TX CMD and rx_valid in the same IDLE cycle
    tx_pkt[0] = 8'h11; tx_pkt[1] = 8'h22;
    rx_pkt[0] = 8'hC3; rx_pkt[1] = 8'h3C;
    @(posedge clk); #1;
    dir_cycles = 0;
    rx_valid = 1'b1;
    rx_byte = rx_pkt[0];
    rx_last = 1'b0;
    send_tx(4'h3, 2);
    check("rx_held_idle", 32'(dir), 32'd0);
    rx_expect(2, 2'b00, 9, 0);
    @(negedge clk);
    check("rx_turn_after_idle", 32'(dir), 32'd1);
    rx_feed(2, 9, 0);
    finish_pkt(6);

    // random RX packets, some with an underrun gap
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 6);
      gi = $urandom_range(1, n);
      gl = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) rx_pkt[i] = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      rx_expect(n, 2'b00, gi, gl);
      rx_feed(n, gi, gl);
      finish_pkt(n + 4 + ((gi < n) ? gl : 0));
    end

    // reset in the middle of RX_DATA
    @(posedge clk); #1;
    bus_exp_q.push_back({1'b0, 8'h00});
    bus_exp_q.push_back({1'b0, exp_cmd(1'b1, 2'b00)});
    bus_exp_q.push_back({1'b1, 8'h5A});
    rx_byte = 8'h5A;
    rx_valid = 1'b1;
    rx_last = 1'b0;
    for (int t = 0; t < 10 && state_dbg != RX_DATA; t++) @(negedge clk);
    check("rst_mid_state", 32'(state_dbg), 32'(RX_DATA));
    check("rst_mid_dir", 32'(dir), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    check("rst_mid_q", 32'(bus_exp_q.size()), 32'd0);
    bus_exp_q.delete();
    tx_exp_q.delete();
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    @(posedge clk); #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rel_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    check("rst_mid_rel_dir", 32'(dir), 32'd0);
    check("rst_mid_rel_idle", 32'(state_dbg), 32'(IDLE));

    // linestate change while IDLE
    set_ls(2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
